ads8321_sampler: RTL and testbench
==================================

// Module: ads8321_sampler
// PURPOSE
//  Upstream/downstream companion of the ADS8321 serial interface. Issues periodic ad_start
//  pulses, consumes ad_data/ad_dval, averages 2^AVG_LOG2 signed 16-bit samples and
//  presents the mean on a valid/ready port to the DSP/UART layer. Flags missed triggers and output overflow.
// PARAMETERS
//  PERIOD_CYC  125  clk cycles between triggers (125 @2.5MHz = 20kS/s); legal >= 24
//  AVG_LOG2    2    log2 of samples per average (0..8; 0 = pass-through)
// PORTS
//  clk         in   1   system clock, same 2.5MHz domain as the ADC interface
//  rst         in   1   synchronous, active-high reset
//  enable      in   1   1 = run periodic sampling; 0 = stop issuing triggers
//  ad_start    out  1   one-cycle trigger pulse to ADC interface
//  ad_busy     in   1   ADC conversion in progress
//  ad_dval     in   1   one-cycle pulse: ad_data valid
//  ad_data     in   16  two's-complement sample (bipolar input)
//  avg_data    out  16  two's-complement averaged sample
//  avg_valid   out  1   avg_data valid; held until accepted
//  avg_ready   in   1   consumer accepts when avg_valid & avg_ready
//  overrun     out  1   sticky: trigger tick occurred while ADC busy/awaiting dval
//  ovf         out  1   sticky: average completed while avg_valid still pending
//  clr_flags   in   1   clears overrun/ovf (lower priority than setting in same cycle)
// BEHAVIOUR
//  Reset: ad_start=0, avg_valid=0, avg_data=0, overrun=0, ovf=0, timer=0, acc=0, sample cnt=0, FSM=IDLE.
//  Timer: counts 0..PERIOD_CYC-1 while enable=1, wraps; tick when count==PERIOD_CYC-1.
//   enable=0 holds timer at 0; first tick PERIOD_CYC cycles after enable rises.
//  FSM IDLE -> (tick & !ad_busy) START: ad_start=1 exactly one cycle -> WAIT.
//   WAIT -> on ad_dval: acc += sign-extended ad_data (width 16+AVG_LOG2), cnt++ -> IDLE.
//   tick while in START/WAIT or ad_busy=1: no trigger, overrun<=1, timer still wraps.
//  Average: when ad_dval brings cnt to 2^AVG_LOG2, next cycle avg_data = acc>>>AVG_LOG2
//   (arithmetic shift, truncation toward -inf), avg_valid=1, acc=0, cnt=0.
//   Latency ad_dval -> avg_valid: 1 cycle.
//  Handshake: avg_valid falls the cycle after valid&ready. If a new average completes while
//   avg_valid=1 & !avg_ready: new result dropped, avg_data unchanged, ovf<=1. If ready is
//   high in that same cycle, new result is loaded, avg_valid stays 1, no ovf.
//  enable falling mid-conversion: WAIT completes, sample accumulated; partial acc then
//   cleared on return to IDLE with enable=0 (no partial average emitted).
//  ad_dval while IDLE (stray): ignored, no accumulation.
//  rst mid-operation: all state to reset values next edge; pending avg_valid dropped.
// CONFIGURATION
//  SAMPLER_OFFSET_EN defined: adds port offset in 16 (signed); each sample becomes
//   sat16(ad_data+offset), saturating at 16'h7FFF / 16'h8000 before accumulation.
//  Not defined: no offset port; ad_data accumulated directly.
// STRUCTURE
//  ads8321_pkg: FSM state encodings (IDLE/START/WAIT), ADC_W=16, MIN_PERIOD=24.
//  Sub-module ads_tick_gen: enable-gated modulo-PERIOD_CYC counter producing tick.
//  Top holds FSM, accumulator, output register and sticky flags.
// TESTING
//  1 AVG_LOG2=2, ADC model returns 100,200,300,400 -> one avg_valid, avg_data=250, ad_start every 125 cycles.
//  2 Samples -1,-1,-1,-2 -> avg_data=16'hFFFE (-2, floor); 16'h7FFF x4 -> 16'h7FFF (no wrap).
//  3 Hold avg_ready=0 across two averages -> first value kept, ovf=1; clr_flags -> ovf=0.
//  4 ADC model keeps ad_busy high 130 cycles -> tick skipped, overrun=1, next trigger at following tick.
//  5 Drop enable after 2 of 4 samples, re-enable -> no output until 4 fresh samples.
//  6 SAMPLER_OFFSET_EN, offset=16'h0100, ad_data=16'h7F80 -> sample saturates to 16'h7FFF.

Source files
------------

// File: rtl/ads8321_pkg.sv
// Shared definitions for the ADS8321 sampler: ADC word width, minimum
// legal trigger period, FSM state encodings and the 16-bit saturation helper.
package ads8321_pkg;

   localparam int ADC_W      = 16;
   localparam int MIN_PERIOD = 24;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;

   // Clamp a 17-bit signed sum into the 16-bit two's-complement range.
   function automatic logic [ADC_W-1:0] sat16(input logic [ADC_W:0] v);
      if (v[ADC_W] != v[ADC_W-1]) begin
         return v[ADC_W] ? 16'h8000 : 16'h7FFF;
      end
      return v[ADC_W-1:0];
   endfunction

endpackage

// File: rtl/ads8321_sampler_if.sv
// Averaged-sample output port of the ADS8321 sampler.
// Handshake: a word transfers on every clock edge where avg_valid and
// avg_ready are both high; the master holds avg_valid and avg_data stable
// until that happens, and the slave may drive avg_ready at any time.
interface ads8321_sampler_if;
   import ads8321_pkg::*;

   logic [ADC_W-1:0] avg_data;
   logic             avg_valid;
   logic             avg_ready;

   modport master (output avg_data, output avg_valid, input avg_ready);
   modport slave  (input avg_data, input avg_valid, output avg_ready);

endinterface

// File: rtl/ads8321_sampler_tick_gen.sv
// Enable-gated modulo-PERIOD_CYC counter. tick_o is high for one cycle when
// the count reaches PERIOD_CYC-1; with enable low the count is held at 0.
// Periods below the ADC minimum are clamped up to MIN_PERIOD.
module ads_tick_gen
   import ads8321_pkg::*;
#(
   parameter int PERIOD_CYC = 125
) (
   input  logic clk,
   input  logic rst,
   input  logic enable_i,
   output logic tick_o
);

   localparam int PERIOD_EFF = (PERIOD_CYC < MIN_PERIOD) ? MIN_PERIOD : PERIOD_CYC;
   localparam int CW         = $clog2(PERIOD_EFF);
   localparam logic [CW-1:0] LAST = CW'(PERIOD_EFF - 1);

   logic [CW-1:0] count_q, count_d;

   // Next count: hold at zero while disabled, wrap after the last count.
   always_comb begin
      count_d = count_q;
      if (!enable_i) begin
         count_d = '0;
      end else if (count_q == LAST) begin
         count_d = '0;
      end else begin
         count_d = count_q + 1'b1;
      end
   end

   // Counter register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign tick_o = enable_i && (count_q == LAST);

endmodule

// File: rtl/ads8321_sampler.sv
// ADS8321 sampler: periodic trigger FSM, 2^AVG_LOG2 sample averager,
// valid/ready output register and sticky overrun/ovf flags.
// Optional build macro SAMPLER_OFFSET_EN adds a signed offset port that is
// added (with saturation) to every sample before accumulation.
module ads8321_sampler
   import ads8321_pkg::*;
#(
   parameter int PERIOD_CYC = 125,
   parameter int AVG_LOG2   = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   output logic             ad_start,
   input  logic             ad_busy,
   input  logic             ad_dval,
   input  logic [ADC_W-1:0] ad_data,
`ifdef SAMPLER_OFFSET_EN
   input  logic [ADC_W-1:0] offset,
`endif
   ads8321_sampler_if.master avg_if,
   output logic             overrun,
   output logic             ovf,
   input  logic             clr_flags,
   output logic [1:0]       dbg_state
);

   localparam int ACC_W = ADC_W + AVG_LOG2;
   localparam int CNT_W = AVG_LOG2 + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

   logic [1:0]              state_q, state_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [ADC_W-1:0]        avg_data_q, avg_data_d;
   logic                    avg_valid_q, avg_valid_d;
   logic                    overrun_q, overrun_d;
   logic                    ovf_q, ovf_d;

   logic                    tick;
   logic signed [ADC_W-1:0] sample;
   logic signed [ACC_W-1:0] acc_sum;
   logic [ADC_W-1:0]        avg_new;
   logic                    avg_done;
   logic                    ovr_set;
   logic                    ovf_set;

   ads_tick_gen #(.PERIOD_CYC(PERIOD_CYC)) u_tick (
      .clk      (clk),
      .rst      (rst),
      .enable_i (enable),
      .tick_o   (tick)
   );

`ifdef SAMPLER_OFFSET_EN
   assign sample = $signed(sat16({ad_data[ADC_W-1], ad_data} + {offset[ADC_W-1], offset}));
`else
   assign sample = $signed(ad_data);
`endif

   // Sign-extended accumulation and the arithmetic-shift mean (floors toward -inf).
   assign acc_sum = acc_q + ACC_W'(sample);
   assign avg_new = ADC_W'(acc_sum >>> AVG_LOG2);

   // Trigger FSM and accumulator: one trigger per free tick, one sample per trigger.
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      avg_done = 1'b0;
      ovr_set  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (tick) begin
               if (!ad_busy) state_d = ST_START;
               else          ovr_set = 1'b1;
            end
            // A partial average is discarded once sampling has been stopped.
            if (!enable) begin
               acc_d = '0;
               cnt_d = '0;
            end
         end
         ST_START: begin
            if (tick) ovr_set = 1'b1;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (tick) ovr_set = 1'b1;
            if (ad_dval) begin
               state_d = ST_IDLE;
               if (cnt_q == CNT_LAST) begin
                  avg_done = 1'b1;
                  acc_d    = '0;
                  cnt_d    = '0;
               end else begin
                  acc_d = acc_sum;
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output register and sticky flags; setting a flag beats clearing it.
   always_comb begin
      avg_data_d  = avg_data_q;
      avg_valid_d = avg_valid_q;
      ovf_set     = 1'b0;
      if (avg_done) begin
         if (avg_valid_q && !avg_if.avg_ready) begin
            ovf_set = 1'b1;
         end else begin
            avg_data_d  = avg_new;
            avg_valid_d = 1'b1;
         end
      end else if (avg_valid_q && avg_if.avg_ready) begin
         avg_valid_d = 1'b0;
      end
      overrun_d = ovr_set ? 1'b1 : (clr_flags ? 1'b0 : overrun_q);
      ovf_d     = ovf_set ? 1'b1 : (clr_flags ? 1'b0 : ovf_q);
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         avg_data_q  <= '0;
         avg_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         avg_data_q  <= avg_data_d;
         avg_valid_q <= avg_valid_d;
         overrun_q   <= overrun_d;
         ovf_q       <= ovf_d;
      end
   end

   assign ad_start         = (state_q == ST_START);
   assign avg_if.avg_data  = avg_data_q;
   assign avg_if.avg_valid = avg_valid_q;
   assign overrun          = overrun_q;
   assign ovf              = ovf_q;
   assign dbg_state        = state_q;

endmodule

// File: tb/tb_ads8321_sampler.sv
// Bench for ads8321_sampler: ADC behavioural model, sample-list averaging
// model compared every cycle, literal expected queue for accepted words,
// and directed checks of trigger timing and sticky flags.
module tb_ads8321_sampler;
   import ads8321_pkg::*;

   localparam int PERIOD = 125;
   localparam int NAVG   = 4;

   logic        clk = 1'b0;
   logic        rst, enable, ad_start, ad_busy, ad_dval, overrun, ovf, clr_flags;
   logic [15:0] ad_data;
   logic [1:0]  dbg_state;
`ifdef SAMPLER_OFFSET_EN
   logic [15:0] offset;
`endif

   ads8321_sampler_if avg_if();

   ads8321_sampler #(.PERIOD_CYC(PERIOD), .AVG_LOG2(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .ad_start  (ad_start),
      .ad_busy   (ad_busy),
      .ad_dval   (ad_dval),
      .ad_data   (ad_data),
`ifdef SAMPLER_OFFSET_EN
      .offset    (offset),
`endif
      .avg_if    (avg_if),
      .overrun   (overrun),
      .ovf       (ovf),
      .clr_flags (clr_flags),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / cycle counter ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- bookkeeping ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // ---------------- ADC behavioural model ----------------
   logic [15:0] adc_q[$];
   logic [15:0] stray_data = '0;
   bit          long_next = 1'b0;
   bit          stray_req = 1'b0;
   bit          dval_real = 1'b0;
   bit          conv_open = 1'b0;
   int          busy_cnt  = 0;

   initial begin
      ad_busy = 1'b0;
      ad_dval = 1'b0;
      ad_data = '0;
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            ad_busy = 1'b0; ad_dval = 1'b0; dval_real = 1'b0; conv_open = 1'b0;
         end else if (ad_dval) begin
            ad_dval = 1'b0; dval_real = 1'b0; conv_open = 1'b0;
         end else if (ad_start) begin
            ad_busy   = 1'b1;
            conv_open = 1'b1;
            busy_cnt  = long_next ? 130 : 16;
            long_next = 1'b0;
         end else if (ad_busy) begin
            busy_cnt--;
            if (busy_cnt == 0) begin
               ad_busy   = 1'b0;
               ad_dval   = 1'b1;
               dval_real = 1'b1;
               ad_data   = (adc_q.size() != 0) ? adc_q.pop_front() : 16'h0000;
            end
         end else if (stray_req) begin
            stray_req = 1'b0;
            ad_dval   = 1'b1;
            dval_real = 1'b0;
            ad_data   = stray_data;
         end
      end
   end

   // ---------------- scoreboard / reference model ----------------
   logic [15:0] exp_q[$];
   int          start_cyc[$];
   int          m_samp[$];
   bit          m_valid = 1'b0;
   logic [15:0] m_data  = '0;
   bit          m_ovf   = 1'b0;
   bit          chk_on  = 1'b0;
   bit          prev_start = 1'b0;

   always @(negedge clk) begin : compare_and_model
      int  s, sum, q;
      bit  done, drop;
      if (chk_on) begin
         chk("avg_valid", avg_if.avg_valid, m_valid);
         chk("ovf", ovf, m_ovf);
         if (m_valid) chk("avg_data", avg_if.avg_data, m_data);
         if (avg_if.avg_valid && avg_if.avg_ready) begin
            if (exp_q.size() == 0) chk("accept_unexpected", 1, 0);
            else chk("accept_data", avg_if.avg_data, exp_q.pop_front());
         end
         if (ad_start) begin
            chk("ad_start_one_cycle", prev_start, 0);
            start_cyc.push_back(cyc);
         end
      end
      prev_start = ad_start;

      // Advance the model to the state expected after the coming edge.
      done = 1'b0;
      drop = 1'b0;
      q    = 0;
      if (rst) begin
         m_samp.delete();
         m_valid = 1'b0;
         m_data  = '0;
         m_ovf   = 1'b0;
      end else begin
         if (ad_dval && dval_real) begin
            s = int'($signed(ad_data));
`ifdef SAMPLER_OFFSET_EN
            s = s + int'($signed(offset));
            if (s > 32767)  s = 32767;
            if (s < -32768) s = -32768;
`endif
            m_samp.push_back(s);
            if (m_samp.size() == NAVG) begin
               sum = 0;
               foreach (m_samp[i]) sum += m_samp[i];
               q = sum / NAVG;
               if ((sum % NAVG) != 0 && sum < 0) q = q - 1;
               m_samp.delete();
               done = 1'b1;
            end
         end else if (!enable && !conv_open) begin
            m_samp.delete();
         end
         if (done) begin
            if (m_valid && !avg_if.avg_ready) drop = 1'b1;
            else begin
               m_data  = 16'(q);
               m_valid = 1'b1;
            end
         end else if (m_valid && avg_if.avg_ready) begin
            m_valid = 1'b0;
         end
         if (drop) m_ovf = 1'b1;
         else if (clr_flags) m_ovf = 1'b0;
      end
   end

   // ---------------- directed stimulus ----------------
   int t0;

   initial begin
      rst = 1'b1; enable = 1'b0; clr_flags = 1'b0; avg_if.avg_ready = 1'b0;
`ifdef SAMPLER_OFFSET_EN
      offset = '0;
`endif
      wait_cyc(3);
      chk_on = 1'b1;
      chk("rst_ad_start", ad_start, 0);
      chk("rst_avg_valid", avg_if.avg_valid, 0);
      chk("rst_avg_data", avg_if.avg_data, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_state", dbg_state, 0);
      rst = 1'b0;
      wait_cyc(2);

      // 1: four positive samples, ready high, triggers every PERIOD cycles
      adc_q = '{16'd100, 16'd200, 16'd300, 16'd400};
      exp_q.push_back(16'd250);
      avg_if.avg_ready = 1'b1;
      start_cyc.delete();
      t0 = cyc;
      enable = 1'b1;
      wait_cyc(4*PERIOD + 30);
      enable = 1'b0;
      wait_cyc(10);
      chk("t1_start_count", start_cyc.size(), 4);
      if (start_cyc.size() == 4) begin
         chk("t1_first_start", start_cyc[0] - t0, PERIOD);
         chk("t1_interval_1", start_cyc[1] - start_cyc[0], PERIOD);
         chk("t1_interval_3", start_cyc[3] - start_cyc[2], PERIOD);
      end
      chk("t1_exp_drained", exp_q.size(), 0);

      // 2: negative floor and positive full scale
      adc_q = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFE,
                16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
      exp_q.push_back(16'hFFFE);
      exp_q.push_back(16'h7FFF);
      enable = 1'b1;
      wait_cyc(8*PERIOD + 30);
      enable = 1'b0;
      wait_cyc(10);
      chk("t2_exp_drained", exp_q.size(), 0);

      // 3: consumer stalls across two averages
      avg_if.avg_ready = 1'b0;
      adc_q = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd1, 16'd2, 16'd3, 16'd4};
      exp_q.push_back(16'd25);
      enable = 1'b1;
      wait_cyc(8*PERIOD + 30);
      enable = 1'b0;
      wait_cyc(5);
      chk("t3_valid_held", avg_if.avg_valid, 1);
      chk("t3_first_kept", avg_if.avg_data, 16'd25);
      chk("t3_ovf_set", ovf, 1);
      clr_flags = 1'b1;
      wait_cyc(1);
      clr_flags = 1'b0;
      chk("t3_ovf_cleared", ovf, 0);
      avg_if.avg_ready = 1'b1;
      wait_cyc(1);
      chk("t3_valid_dropped", avg_if.avg_valid, 0);
      chk("t3_exp_drained", exp_q.size(), 0);

      // 4: long conversion swallows one tick
      chk("t4_overrun_clear_before", overrun, 0);
      long_next = 1'b1;
      adc_q = '{16'd1000, 16'd2000, 16'd3000, 16'd4000};
      exp_q.push_back(16'd2500);
      start_cyc.delete();
      t0 = cyc;
      enable = 1'b1;
      wait_cyc(PERIOD + 5);
      chk("t4_overrun_not_yet", overrun, 0);
      wait_cyc(4*PERIOD + 30);
      enable = 1'b0;
      wait_cyc(10);
      chk("t4_overrun_set", overrun, 1);
      chk("t4_start_count", start_cyc.size(), 4);
      if (start_cyc.size() == 4) begin
         chk("t4_first_start", start_cyc[0] - t0, PERIOD);
         chk("t4_skipped_tick", start_cyc[1] - start_cyc[0], 2*PERIOD);
         chk("t4_resumed", start_cyc[2] - start_cyc[1], PERIOD);
      end
      clr_flags = 1'b1;
      wait_cyc(1);
      clr_flags = 1'b0;
      chk("t4_overrun_cleared", overrun, 0);
      chk("t4_exp_drained", exp_q.size(), 0);

      // 5: stop after two samples, stray dval while idle, then four fresh samples
      adc_q = '{16'd7, 16'd7};
      enable = 1'b1;
      wait_cyc(2*PERIOD + 30);
      enable = 1'b0;
      wait_cyc(5);
      stray_data = 16'd5000;
      stray_req  = 1'b1;
      wait_cyc(10);
      chk("t5_no_partial_output", avg_if.avg_valid, 0);
      adc_q = '{16'd1, 16'd2, 16'd3, 16'd4};
      exp_q.push_back(16'd2);
      enable = 1'b1;
      wait_cyc(4*PERIOD + 30);
      enable = 1'b0;
      wait_cyc(10);
      chk("t5_exp_drained", exp_q.size(), 0);

`ifdef SAMPLER_OFFSET_EN
      // 6: offset pushes the sample into positive saturation
      offset = 16'h0100;
      adc_q  = '{16'h7F80, 16'h7F80, 16'h7F80, 16'h7F80};
      exp_q.push_back(16'h7FFF);
      enable = 1'b1;
      wait_cyc(4*PERIOD + 30);
      enable = 1'b0;
      wait_cyc(10);
      offset = '0;
      chk("t6_exp_drained", exp_q.size(), 0);
`endif

      // 7: reset while a result is pending
      avg_if.avg_ready = 1'b0;
      adc_q = '{16'd8, 16'd8, 16'd8, 16'd8};
      enable = 1'b1;
      wait_cyc(4*PERIOD + 30);
      chk("t7_pending", avg_if.avg_valid, 1);
      rst = 1'b1;
      wait_cyc(1);
      chk("t7_rst_valid", avg_if.avg_valid, 0);
      chk("t7_rst_data", avg_if.avg_data, 0);
      chk("t7_rst_state", dbg_state, 0);
      rst = 1'b0;
      enable = 1'b0;
      avg_if.avg_ready = 1'b1;
      wait_cyc(10);
      chk("final_exp_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
